// File: rtl/alu_iter.sv
// Iterative RV32-style ALU with a one-bit-per-cycle shifter.
//
// Accepts one operation per request. Non-shift operations take one cycle.
// Shifts take one cycle per bit of shift amount. The result, zero flag and
// illegal flag are registered. They update together with the done pulse and
// hold until the next completion.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   start_i        request, sampled only while idle
//   aluoperacion_i 4-bit operation code
//   negzero_i      inverts the zero flag (branch-not-equal style conditions)
//   a_i, b_i       operands; b_i[SHAMT_W-1:0] is the shift amount
//   busy_o         high whenever an operation is in flight
//   done_o         one-cycle completion pulse
//   result_o       operation result
//   zero_o         (result == 0) XOR latched negzero
//   illegal_o      unsupported operation code
module alu_iter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [3:0]      aluoperacion_i,
    input  logic            negzero_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    localparam logic [SHAMT_W-1:0] CntOne = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   wreg_q, wreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic              nz_q, nz_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic [XLEN-1:0]   alu_res;
    logic              alu_legal;
    logic              is_shift;
    logic [XLEN-1:0]   shift_one;
    logic [SHAMT_W-1:0] shamt;

    assign shamt    = b_i[SHAMT_W-1:0];
    assign is_shift = (aluoperacion_i == 4'b1000) || (aluoperacion_i == 4'b1001) ||
                      (aluoperacion_i == 4'b1010);

    // Single-cycle operations, evaluated directly on the request inputs.
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (aluoperacion_i)
            4'b0000: alu_res = a_i + b_i;
            4'b0001: alu_res = a_i & b_i;
            4'b0010: alu_res = a_i | b_i;
            4'b0011: alu_res = a_i ^ b_i;
            4'b0100: alu_res = a_i - b_i;
            4'b0101: alu_res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            4'b0110: alu_res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default: alu_legal = 1'b0;
        endcase
    end

    // One-bit step of the shift held in op_q (low two bits select the kind).
    always_comb begin
        shift_one = wreg_q;
        case (op_q[1:0])
            2'b00:   shift_one = {wreg_q[XLEN-2:0], 1'b0};
            2'b01:   shift_one = {1'b0, wreg_q[XLEN-1:1]};
            2'b10:   shift_one = {wreg_q[XLEN-1], wreg_q[XLEN-1:1]};
            default: shift_one = wreg_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wreg_d    = wreg_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        nz_d      = nz_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d = aluoperacion_i;
                    nz_d = negzero_i;
                    if (is_shift) begin
                        wreg_d = a_i;
                        cnt_d  = shamt;
                        if (shamt == '0) begin
                            state_d   = StDone;
                            result_d  = a_i;
                            illegal_d = 1'b0;
                            zero_d    = (a_i == '0) ^ negzero_i;
                        end else begin
                            state_d = StShift;
                        end
                    end else if (alu_legal) begin
                        state_d   = StDone;
                        result_d  = alu_res;
                        illegal_d = 1'b0;
                        zero_d    = (alu_res == '0) ^ negzero_i;
                    end else begin
                        state_d   = StDone;
                        result_d  = '0;
                        illegal_d = 1'b1;
                        zero_d    = ~negzero_i;
                    end
                end
            end
            StShift: begin
                wreg_d = shift_one;
                cnt_d  = cnt_q - CntOne;
                // Last step: publish the shifted value together with the move to done.
                if (cnt_q == CntOne) begin
                    state_d   = StDone;
                    result_d  = shift_one;
                    illegal_d = 1'b0;
                    zero_d    = (shift_one == '0) ^ nz_q;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            wreg_q    <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            nz_q      <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wreg_q    <= wreg_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            nz_q      <= nz_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone);
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = illegal_q;

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-002 Parameter: XLEN, default 32, operand/result width; SHAMT_W = log2(XLEN), default 5.
REQ-003 clk_i  in  1  rising-edge clock.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 start_i  in  1  request; sampled only in IDLE.
REQ-006 aluoperacion_i  in  4  operation code (see REQ-013).
REQ-007 negzero_i  in  1  branch-condition inversion flag.
REQ-008 a_i  in  XLEN  operand A (rs1).
REQ-009 b_i  in  XLEN  operand B (rs2/immediate); b_i[SHAMT_W-1:0] is the shift amount.
REQ-010 busy_o  out  1  high whenever state is not IDLE.
REQ-011 done_o  out  1  one-cycle completion pulse; result_o, zero_o and illegal_o are valid in that cycle and hold until the next completion.
REQ-012 result_o  out  XLEN;  zero_o  out  1  = (result==0) XOR latched negzero;  illegal_o  out  1  unsupported op code.

Function
REQ-013 Op codes: 0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SUB, 0101 SLT (signed, result 0/1), 0110 SLTU (unsigned, 0/1), 1000 SLL, 1001 SRL, 1010 SRA; all others illegal.
REQ-014 States: IDLE, SHIFT, DONE.
REQ-015 IDLE and start_i=1: latch a_i, b_i, aluoperacion_i, negzero_i; the acceptance edge is cycle 0.
REQ-016 Non-shift legal op: compute in one step, go to DONE; done_o=1 in cycle 1.
REQ-017 Illegal op: result 0, illegal_o=1, go to DONE; done_o=1 in cycle 1; zero_o = 1 XOR negzero.
REQ-018 Shift op: load working register with A and counter with shamt; shamt=0 goes directly to DONE (done in cycle 1).
REQ-019 SHIFT: each cycle shift working register by exactly one bit (SLL left, zero-fill; SRL right, zero-fill; SRA right, sign-fill from bit XLEN-1) and decrement counter; on the cycle counter reaches 0, go to DONE; done_o occurs in cycle shamt+1.
REQ-020 DONE: assert done_o, update result_o/zero_o/illegal_o, return to IDLE next cycle.
REQ-021 start_i asserted while busy_o=1 SHALL be ignored and not queued; input changes after acceptance SHALL not affect the operation in flight.
REQ-022 ADD/SUB wrap modulo 2^XLEN; no overflow flag.
REQ-023 Shift amount uses only b[SHAMT_W-1:0]; upper bits ignored.
REQ-024 Maximum throughput: one op per 2 cycles (non-shift), shamt+2 cycles (shift).

Reset
REQ-025 rst_i=1 at a clock edge SHALL force IDLE, busy_o=0, done_o=0, result_o=0, zero_o=0, illegal_o=0, counter=0, regardless of state; an operation in flight is discarded with no done_o.
REQ-026 start_i in the reset cycle SHALL be ignored; first acceptance is the first edge with rst_i=0.

Verification
REQ-027 ADD: a=0x7FFFFFFF, b=1, op 0000, negzero 0 -> cycle 1 done_o=1, result 0x80000000, zero_o 0; SUB a=5, b=5, negzero 1 (BNE) -> result 0, zero_o 0.
REQ-028 SLT/SLTU: a=0xFFFFFFFF, b=1 -> SLT result 1, SLTU result 0; with negzero 1 -> zero_o 1 and 0 respectively.
REQ-029 SRA a=0x80000000, b=0x00000024 (shamt 4) -> done_o exactly in cycle 5, result 0xF8000000, busy_o high cycles 1-5; SLL shamt 0 -> done in cycle 1, result = a.
REQ-030 SRL a=0xFFFFFFFF, shamt 31 with start_i held high and a_i/b_i changed during SHIFT -> single done_o at cycle 32, result 0x00000001, no second operation accepted until IDLE.
REQ-031 Illegal op 1111, negzero 0 -> cycle 1 done_o=1, illegal_o=1, result 0, zero_o 1.
REQ-032 Reset mid-SHIFT (SLL shamt 20, rst_i at cycle 6) -> next cycle busy_o=0, all outputs 0, no done_o; new ADD accepted after reset completes normally.
